// File: rtl/ecc_encoder_pipe.sv
// ecc_encoder_pipe: streaming extended-Hamming encoder, two registered stages
// with full valid/ready backpressure. Mode 0 emits an 8-bit (H1) codeword from
// Data_In[3:0]; modes 1..3 emit a 16-bit (H2) codeword from Data_In[10:0].
// Optional feature macro: ECC_ERR_INJECT_EN adds inject_en / inject_mask ports
// that XOR a per-word mask onto the encoded output.
module ecc_encoder_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic [1:0]            Codeword_Width,
`ifdef ECC_ERR_INJECT_EN
    input  logic                  inject_en,
    input  logic [DATA_WIDTH-1:0] inject_mask,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] CodeWord,
    output logic [1:0]            out_width,
    output logic [15:0]           word_count
);

    // 8-bit extended Hamming codeword: data in [7:4], parity in [2:0], overall parity in [3]
    function automatic logic [DATA_WIDTH-1:0] encode_h1(input logic [3:0] d);
        logic [7:0] cw;
        cw      = 8'd0;
        cw[7:4] = d;
        cw[2]   = cw[7] ^ cw[6] ^ cw[5];
        cw[1]   = cw[7] ^ cw[6] ^ cw[4];
        cw[0]   = cw[7] ^ cw[5] ^ cw[4];
        cw[3]   = ^{cw[7:4], cw[2:0]};
        encode_h1 = {{(DATA_WIDTH-8){1'b0}}, cw};
    endfunction

    // 16-bit extended Hamming codeword: data in [15:5], parity in [3:0], overall parity in [4]
    function automatic logic [DATA_WIDTH-1:0] encode_h2(input logic [10:0] d);
        logic [15:0] cw;
        cw       = 16'd0;
        cw[15:5] = d;
        cw[3]    = ^cw[15:9];
        cw[2]    = (^cw[15:12]) ^ (^cw[8:6]);
        cw[1]    = cw[15] ^ cw[14] ^ cw[11] ^ cw[10] ^ cw[8] ^ cw[7] ^ cw[5];
        cw[0]    = cw[15] ^ cw[13] ^ cw[11] ^ cw[9] ^ cw[8] ^ cw[6] ^ cw[5];
        cw[4]    = ^{cw[15:5], cw[3:0]};
        encode_h2 = {{(DATA_WIDTH-16){1'b0}}, cw};
    endfunction

    // Stage 1 state (raw word) and stage 2 state (encoded word)
    logic                  s1_valid_q, s1_valid_d;
    logic [10:0]           s1_data_q,  s1_data_d;
    logic [1:0]            s1_width_q, s1_width_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_cw_q,    s2_cw_d;
    logic [1:0]            s2_width_q, s2_width_d;
    logic [15:0]           count_q,    count_d;
`ifdef ECC_ERR_INJECT_EN
    logic                  s1_inj_en_q,   s1_inj_en_d;
    logic [DATA_WIDTH-1:0] s1_inj_mask_q, s1_inj_mask_d;
`endif

    logic                  in_hs_s;
    logic                  out_hs_s;
    logic                  s2_load_s;
    logic                  in_ready_s;
    logic [DATA_WIDTH-1:0] enc_s;
    logic                  unused_data_s;

    // Only the low 11 data bits ever reach a codeword
    assign unused_data_s = ^Data_In[DATA_WIDTH-1:11];

    // Handshake and stage-advance terms; in_ready depends on out_ready but never on in_valid
    always_comb begin
        s2_load_s  = !s2_valid_q || out_ready;
        in_ready_s = !s1_valid_q || s2_load_s;
        in_hs_s    = in_valid && in_ready_s;
        out_hs_s   = s2_valid_q && out_ready;
    end

    // Encoder for the word currently held in stage 1, with optional error mask
    always_comb begin
        enc_s = {DATA_WIDTH{1'b0}};
        case (s1_width_q)
            2'd0:    enc_s = encode_h1(s1_data_q[3:0]);
            default: enc_s = encode_h2(s1_data_q);
        endcase
`ifdef ECC_ERR_INJECT_EN
        if (s1_inj_en_q) begin
            enc_s = enc_s ^ s1_inj_mask_q;
        end else begin
            enc_s = enc_s;
        end
`endif
    end

    // Next-state logic for both pipeline stages and the handoff counter
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_width_d = s1_width_q;
        s2_valid_d = s2_valid_q;
        s2_cw_d    = s2_cw_q;
        s2_width_d = s2_width_q;
        count_d    = count_q;
`ifdef ECC_ERR_INJECT_EN
        s1_inj_en_d   = s1_inj_en_q;
        s1_inj_mask_d = s1_inj_mask_q;
`endif

        if (in_hs_s) begin
            s1_valid_d = 1'b1;
            s1_data_d  = Data_In[10:0];
            s1_width_d = Codeword_Width;
`ifdef ECC_ERR_INJECT_EN
            s1_inj_en_d   = inject_en;
            s1_inj_mask_d = inject_mask;
`endif
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cw_d    = enc_s;
                s2_width_d = s1_width_q;
            end else begin
                s2_cw_d    = s2_cw_q;
                s2_width_d = s2_width_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (out_hs_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= 11'd0;
            s1_width_q <= 2'd0;
            s2_valid_q <= 1'b0;
            s2_cw_q    <= {DATA_WIDTH{1'b0}};
            s2_width_q <= 2'd0;
            count_q    <= 16'd0;
`ifdef ECC_ERR_INJECT_EN
            s1_inj_en_q   <= 1'b0;
            s1_inj_mask_q <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_width_q <= s1_width_d;
            s2_valid_q <= s2_valid_d;
            s2_cw_q    <= s2_cw_d;
            s2_width_q <= s2_width_d;
            count_q    <= count_d;
`ifdef ECC_ERR_INJECT_EN
            s1_inj_en_q   <= s1_inj_en_d;
            s1_inj_mask_q <= s1_inj_mask_d;
`endif
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_q;
    assign CodeWord   = s2_cw_q;
    assign out_width  = s2_width_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_ecc_encoder_pipe.sv
// Self-checking bench for ecc_encoder_pipe: directed cases plus randomized
// traffic scored against a queue-based reference model.
module tb_ecc_encoder_pipe;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] Data_In = '0;
    logic [1:0]    Codeword_Width = 2'd0;
    logic          inject_en = 1'b0;
    logic [DW-1:0] inject_mask = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] CodeWord;
    logic [1:0]    out_width;
    logic [15:0]   word_count;

    logic          nxt_inj_en = 1'b0;
    logic [DW-1:0] nxt_inj_mask = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] exp_count = 16'd0;

    typedef struct {
        logic [DW-1:0] cw;
        logic [1:0]    w;
        int            t;
    } exp_t;
    exp_t exp_q[$];

    ecc_encoder_pipe #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .Data_In        (Data_In),
        .Codeword_Width (Codeword_Width),
`ifdef ECC_ERR_INJECT_EN
        .inject_en      (inject_en),
        .inject_mask    (inject_mask),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .CodeWord       (CodeWord),
        .out_width      (out_width),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: place the data, then each parity bit is the XOR over its coverage mask
    function automatic logic [DW-1:0] ref_encode(input logic [DW-1:0] d, input logic [1:0] w);
        logic [DW-1:0] cw;
        if (w == 2'd0) begin
            cw    = {28'd0, d[3:0]} << 4;
            cw[2] = ^(cw & 32'h0000_00E0);
            cw[1] = ^(cw & 32'h0000_00D0);
            cw[0] = ^(cw & 32'h0000_00B0);
            cw[3] = ^cw;
        end else begin
            cw    = {21'd0, d[10:0]} << 5;
            cw[3] = ^(cw & 32'h0000_FE00);
            cw[2] = ^(cw & 32'h0000_F1C0);
            cw[1] = ^(cw & 32'h0000_CDA0);
            cw[0] = ^(cw & 32'h0000_AB60);
            cw[4] = ^cw;
        end
        return cw;
    endfunction

    // One cycle: drive at negedge, check against the model, then update the model
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic [1:0] w, input logic ordy);
        exp_t e;
        logic exp_ov;
        @(negedge clk);
        in_valid       = iv;
        Data_In        = d;
        Codeword_Width = w;
        out_ready      = ordy;
        inject_en      = nxt_inj_en;
        inject_mask    = nxt_inj_mask;
        #1;
        cyc++;
        check_eq("word_count", word_count, exp_count);
        check_eq("in_ready", in_ready, (exp_q.size() < 2) || ordy);
        exp_ov = 1'b0;
        if (exp_q.size() > 0) exp_ov = (cyc - exp_q[0].t) >= 2;
        check_eq("out_valid", out_valid, exp_ov);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("codeword", CodeWord, e.cw);
                check_eq("out_width", out_width, e.w);
                exp_count = exp_count + 16'd1;
            end
        end
        if (in_valid && in_ready) begin
            e.cw = ref_encode(d, w);
            if (inject_en) e.cw = e.cw ^ inject_mask;
            e.w = w;
            e.t = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        exp_q.delete();
        exp_count = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_codeword", CodeWord, 32'h0);
        check_eq("rst_out_width", out_width, 2'd0);
        check_eq("rst_word_count", word_count, 16'd0);
    endtask

    initial begin
        apply_reset();

        // Single mode-0 word: two-cycle latency
        step(1'b1, 32'hB, 2'd0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("lat_not_yet", out_valid, 1'b0);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("lat_valid", out_valid, 1'b1);
        check_eq("b_codeword", CodeWord, 32'h0000_00B1);
        check_eq("b_width", out_width, 2'd0);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("b_count", word_count, 16'd1);

        // Back-to-back mixed modes
        step(1'b1, 32'hF, 2'd0, 1'b1);
        step(1'b1, 32'h7FF, 2'd1, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("f_codeword", CodeWord, 32'h0000_00FF);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("7ff_codeword", CodeWord, 32'h0000_FFFF);
        check_eq("7ff_width", out_width, 2'd1);

        // Upper data bits must be ignored
        step(1'b1, 32'hDEAD_B001, 2'd1, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("junk_codeword", CodeWord, 32'h0000_0033);
        step(1'b0, 32'h0, 2'd0, 1'b1);

        // Backpressure: five stalled cycles with three words offered
        apply_reset();
        step(1'b1, 32'hB, 2'd0, 1'b0);
        step(1'b1, 32'h001, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hF, 2'd0, 1'b0);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_hold_cw", CodeWord, 32'h0000_00B1);
            check_eq("bp_hold_width", out_width, 2'd0);
        end
        step(1'b1, 32'hF, 2'd0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("bp_count", word_count, 16'd3);

        // Asynchronous reset with two words in flight
        step(1'b1, 32'h5, 2'd0, 1'b0);
        step(1'b1, 32'h123, 2'd2, 1'b0);
        step(1'b0, 32'h0, 2'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", out_valid, 1'b0);
        check_eq("async_word_count", word_count, 16'd0);
        check_eq("async_codeword", CodeWord, 32'h0);
        exp_q.delete();
        exp_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("rst_no_stale", out_valid, 1'b0);

`ifdef ECC_ERR_INJECT_EN
        // Error injection flips the masked bits of that word only
        nxt_inj_en   = 1'b1;
        nxt_inj_mask = 32'h10;
        step(1'b1, 32'hB, 2'd0, 1'b1);
        nxt_inj_en   = 1'b0;
        nxt_inj_mask = 32'h0;
        step(1'b1, 32'hB, 2'd0, 1'b1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("inj_codeword", CodeWord, 32'h0000_00A1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("noinj_codeword", CodeWord, 32'h0000_00B1);
        step(1'b0, 32'h0, 2'd0, 1'b1);
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
`ifdef ECC_ERR_INJECT_EN
            nxt_inj_en   = ($urandom_range(0, 7) == 0);
            nxt_inj_mask = $urandom;
`endif
            step($urandom_range(0, 9) < 7, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        end
        nxt_inj_en = 1'b0;
        repeat (4) step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("rand_drained", out_valid, 1'b0);

        // Counter wrap from 16'hFFFF to 0 under full-rate streaming
        apply_reset();
        for (int i = 0; i < 70000 && exp_count != 16'hFFFF; i++) begin
            step(1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1);
        end
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("wrap_ffff", word_count, 16'hFFFF);
        step(1'b0, 32'h0, 2'd0, 1'b1);
        check_eq("wrap_zero", word_count, 16'd0);
        repeat (2) step(1'b0, 32'h0, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecc_encoder_pipe.md
Name: ecc_encoder_pipe

Overview:
- Streaming extended-Hamming encoder: the transmit-side counterpart of the syndrome calculator.
- Accepts raw data words over a valid/ready handshake and appends parity bits.
- Emits codewords whose syndrome under the H1 (8-bit) or H2 (16-bit) matrix is zero.
- Two-stage registered pipeline with full backpressure. Sits between the data source and the channel or error-injection path that feeds the decoder.

Parameters:
- DATA_WIDTH, 32, width of the Data_In and CodeWord buses. Must be >= 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  Data_In/Codeword_Width valid
- in_ready  output  1  encoder can accept a word this cycle
- Data_In  input  DATA_WIDTH  raw data; mode 0 uses [3:0], otherwise uses [10:0]; other bits ignored
- Codeword_Width  input  2  0 = 8-bit codeword (H1); 1..3 = 16-bit codeword (H2)
- out_valid  output  1  CodeWord valid
- out_ready  input  1  downstream accepts CodeWord
- CodeWord  output  DATA_WIDTH  encoded word; bits above 7 (mode 0) or above 15 (mode !=0) are 0
- out_width  output  2  Codeword_Width captured with this word
- word_count  output  16  number of codewords handed off since reset

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, CodeWord=0, out_width=0, word_count=0. in_ready=1 after reset.
- Stage 1 registers Data_In and Codeword_Width on an input handshake (in_valid && in_ready).
- Stage 2 registers the encoded codeword from stage 1.
- Stage 2 loads when it is empty or when out_ready=1.
- Stage 1 advances when stage 2 loads.
- in_ready = !s1_valid || stage-2 load. This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: accept at edge N gives out_valid at edge N+2, provided out_ready was high. Throughput is 1 word/cycle.
- Backpressure: while out_valid && !out_ready, CodeWord and out_width hold stable and both stages hold. At most 2 words are in flight.
- Simultaneous output handshake and stage-1 refill in the same cycle: no bubble, no loss.
- 8-bit encode (d = Data_In[3:0]):
  - cw[7:4] = d
  - cw[2] = cw7^cw6^cw5
  - cw[1] = cw7^cw6^cw4
  - cw[0] = cw7^cw5^cw4
  - cw[3] = XOR of cw[7:4] and cw[2:0]
- 16-bit encode (d = Data_In[10:0]):
  - cw[15:5] = d
  - cw[3] = ^cw[15:9]
  - cw[2] = ^cw[15:12] ^ ^cw[8:6]
  - cw[1] = cw15^cw14^cw11^cw10^cw8^cw7^cw5
  - cw[0] = cw15^cw13^cw11^cw9^cw8^cw6^cw5
  - cw[4] = XOR of cw[15:5] and cw[3:0]
- Mode is per word: consecutive words may alternate modes with no bubble.
- word_count increments on every output handshake (out_valid && out_ready) and wraps 16'hFFFF -> 0.
- Reset asserted mid-stream: in-flight words are discarded, nothing is emitted after release, and word_count=0.

Optional Feature:
- Macro ECC_ERR_INJECT_EN.
- Defined: adds ports inject_en (input, 1) and inject_mask (input, DATA_WIDTH). Both are sampled with the input handshake and carried through the pipeline alongside the word.
- When the captured inject_en=1, the stage-2 output is CodeWord = encoded ^ captured inject_mask. The mask is applied across the full width, so the zero-upper-bits rule is waived for that word.
- word_count counts injected words like any other.
- Undefined: the ports do not exist and CodeWord is always the clean encoding.

Test Plan:
- Reset, then mode 0, Data_In=4'hB with out_ready=1 -> out_valid 2 cycles later; CodeWord=32'h000000B1, out_width=0, word_count=1.
- Mode 0 Data_In=4'hF, then mode 1 Data_In=11'h7FF back-to-back -> CodeWord 32'h000000FF then 32'h0000FFFF on consecutive cycles.
- Mode 1 Data_In=11'h001 with junk in Data_In[31:11] -> CodeWord=32'h00000033.
- Hold out_ready=0 for 5 cycles while pushing 3 words -> in_ready drops after 2 accepts and CodeWord is stable. Release -> 3 words in order, word_count=3.
- Assert rst_n=0 with 2 words in flight -> out_valid=0 immediately (asynchronous); after release no stale output and word_count=0. Separately, preload word_count=16'hFFFF -> the next handshake wraps it to 0.
- With ECC_ERR_INJECT_EN: mode 0 Data_In=4'hB, inject_en=1, mask=32'h10 -> CodeWord=32'hA1. With inject_en=0 -> CodeWord=32'hB1.
